memory_access: RTL

- Memory stage that consumes the execute stage's results: the address from aluResult, the store data from writeData, and zero together with Branch for the branch decision.
- Runs a registered request/acknowledge transaction to data memory and stalls the pipeline until the access completes.
- Returns load data and reports the PCSrc branch decision back to fetch.
- Sits between execute and writeback in the LEGv8 core.

---
 rtl/memory_access.sv | 116 +++++++++++
 1 files changed

// File: rtl/memory_access.sv
// rtl/memory_access.sv - LEGv8 memory stage: registered req/ack data-memory access with pipeline stall and branch decision
// Optional alignment abort when MEM_ALIGN_CHECK_EN is defined.
module memory_access #(
    parameter int N       = 64,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         valid_M,
    input  logic         MemRead_M,
    input  logic         MemWrite_M,
    input  logic         Branch_M,
    input  logic         zero_M,
    input  logic [N-1:0] aluResult_M,
    input  logic [N-1:0] writeData_M,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic [N-1:0] readData_M,
    output logic         PCSrc_M,
    output logic         stall_M,
    output logic         done_M,
    output logic         err_M
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          err_q;
    logic          memop;
    logic          accept;
    logic          misaligned;

    assign memop  = MemRead_M | MemWrite_M;
    assign accept = (state == IDLE) & valid_M & memop;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = |aluResult_M[2:0];
`else
    assign misaligned = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            readData_M <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mem_addr  <= aluResult_M;
                        mem_wdata <= writeData_M;
                        // A simultaneous read+write request is treated as a write
                        mem_we    <= MemWrite_M;
                        cnt       <= '0;
                        err_q     <= misaligned;
                        if (misaligned) begin
                            state <= DONE;
                        end else begin
                            mem_req <= 1'b1;
                            state   <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // The ack takes priority over a timeout in the same cycle
                    if (mem_ack) begin
                        if (!mem_we) begin
                            readData_M <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        err_q   <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        err_q   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign PCSrc_M = Branch_M & zero_M & valid_M;
    assign stall_M = reset & ((state == BUSY) | accept);
    assign done_M  = reset & ((state == DONE) | ((state == IDLE) & valid_M & ~memop));
    assign err_M   = (state == DONE) & err_q;

endmodule
